// File: rtl/uart_rx_pkg.sv
// Shared types and tick constants for the oversampling UART receiver.
// UART_RX_PARITY_EN adds the even-parity PARITY state to the enum.
package uart_rx_pkg;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rxState_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_t;
`endif

   localparam int         OS_FACTOR   = 16;
   localparam logic [3:0] VOTE_TICK_A = 4'd7;
   localparam logic [3:0] VOTE_TICK_B = 4'd8;
   localparam logic [3:0] VOTE_TICK_C = 4'd9;
   localparam logic [3:0] TICK_LAST   = 4'd15;

   function automatic logic majority3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line synchronizer, falling-edge detect and 3-sample majority vote.
module uart_rx_sync
   import uart_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic rxIn,
   input  logic tick,
   output logic rxSync,
   output logic fallEdge,
   output logic vote
);

   logic [SYNC_STAGES-1:0] syncChain;
   logic                   syncPrev;
   logic [1:0]             history;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         syncChain <= '1;
         syncPrev  <= 1'b1;
         history   <= 2'b11;
      end else begin
         syncChain <= {syncChain[SYNC_STAGES-2:0], rxIn};
         syncPrev  <= rxSync;
         if (tick) history <= {history[0], rxSync};
      end
   end

   assign rxSync   = syncChain[SYNC_STAGES-1];
   assign fallEdge = syncPrev & ~rxSync;
   // Window is the two previous tick samples plus the current one, so the
   // vote evaluated on tick 9 covers ticks 7, 8 and 9.
   assign vote     = majority3({history, rxSync});

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling 8-bit UART receiver with valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 framing; default build is 8N1.
//
// state  | meaning
// IDLE   | waiting for a synced falling edge (blocked while rxBreak)
// START  | validating start bit; vote 1 is a false start
// DATA   | shifting 8 data bits LSB first
// PARITY | sampling even parity bit (UART_RX_PARITY_EN only)
// STOP   | stop decision at tick 9, then straight back to IDLE
module uart_rx_oversample
   import uart_rx_pkg::*;
#(
   parameter int CLOCK_RATE  = 12000000,
   parameter int BAUD_RATE   = 9600,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rxEn,
   input  logic       rxIn,
   output logic [7:0] rxOut,
   output logic       rxValid,
   input  logic       rxReady,
   output logic       rxBusy,
   output logic       rxErr,
   output logic       rxOvr,
   output logic       rxBreak
);

   localparam int OS_DIV = (CLOCK_RATE + (BAUD_RATE * OS_FACTOR) / 2) / (BAUD_RATE * OS_FACTOR);
   localparam int PRE_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

   rxState_t   state, stateNext;
   logic [PRE_W-1:0] preCnt;
   logic [3:0] tickCnt;
   logic       tick, decide, boundary, startFrame;
   logic       rxSync, fallEdge, vote;
   logic [7:0] shiftReg;
   logic [2:0] bitIdx;
   logic       offer, frameErr, breakDet, canLoad, parOk;

   uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rstn     (rstn),
      .rxIn     (rxIn),
      .tick     (tick),
      .rxSync   (rxSync),
      .fallEdge (fallEdge),
      .vote     (vote)
   );

   assign tick       = (preCnt == '0);
   assign decide     = tick && (tickCnt == VOTE_TICK_C);
   assign boundary   = tick && (tickCnt == TICK_LAST);
   assign startFrame = rxEn && (state == IDLE) && fallEdge && !rxBreak;
   assign rxBusy     = (state != IDLE);
   assign canLoad    = !rxValid || rxReady;

   // Prescaler down-counter; restarting it on the start edge aligns tick 0.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         preCnt  <= PRE_W'(OS_DIV - 1);
         tickCnt <= '0;
      end else if (startFrame) begin
         preCnt  <= PRE_W'(OS_DIV - 1);
         tickCnt <= '0;
      end else if (tick) begin
         preCnt  <= PRE_W'(OS_DIV - 1);
         tickCnt <= tickCnt + 4'd1;
      end else begin
         preCnt  <= preCnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      offer     = 1'b0;
      frameErr  = 1'b0;
      breakDet  = 1'b0;
      if (!rxEn) begin
         stateNext = IDLE;
      end else begin
         case (state)
            IDLE:  if (startFrame) stateNext = START;
            START: begin
               if (decide && vote) stateNext = IDLE;
               else if (boundary)  stateNext = DATA;
            end
            DATA: begin
               if (boundary && bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  stateNext = PARITY;
`else
                  stateNext = STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (boundary) stateNext = STOP;
`endif
            STOP: begin
               if (decide) begin
                  stateNext = IDLE;
                  if (vote && parOk) begin
                     offer = 1'b1;
                  end else begin
                     frameErr = 1'b1;
                     breakDet = !vote && (shiftReg == 8'h00);
                  end
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         shiftReg <= '0;
         bitIdx   <= '0;
      end else begin
         if (startFrame)                    bitIdx <= '0;
         else if (state == DATA && boundary) bitIdx <= bitIdx + 3'd1;
         if (state == DATA && decide) shiftReg <= {vote, shiftReg[7:1]};
      end
   end

`ifdef UART_RX_PARITY_EN
   logic parErr;
   always_ff @(posedge clk) begin
      if (!rstn)                          parErr <= 1'b0;
      else if (startFrame)                parErr <= 1'b0;
      else if (state == PARITY && decide) parErr <= vote ^ (^shiftReg);
   end
   assign parOk = !parErr;
`else
   assign parOk = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rxOut   <= '0;
         rxValid <= 1'b0;
         rxErr   <= 1'b0;
         rxOvr   <= 1'b0;
         rxBreak <= 1'b0;
      end else begin
         rxErr <= frameErr;
         rxOvr <= offer && !canLoad;
         if (offer && canLoad) begin
            rxOut   <= shiftReg;
            rxValid <= 1'b1;
         end else if (rxReady) begin
            rxValid <= 1'b0;
         end
         if (breakDet)    rxBreak <= 1'b1;
         else if (rxSync) rxBreak <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample with a byte scoreboard queue.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

   localparam int BAUD     = 9600;
   localparam int CLK_RATE = BAUD * 64;
   localparam int BIT_CLKS = 64;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rxEn = 1'b0;
   logic       rxIn = 1'b1;
   logic       rxReady = 1'b0;
   logic [7:0] rxOut;
   logic       rxValid, rxBusy, rxErr, rxOvr, rxBreak;

   int nVec = 0;
   int nMis = 0;
   int errCnt = 0;
   int ovrCnt = 0;
   int busyCnt = 0;
   logic [7:0] expQ[$];

   uart_rx_oversample #(
      .CLOCK_RATE  (CLK_RATE),
      .BAUD_RATE   (BAUD),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .rxEn    (rxEn),
      .rxIn    (rxIn),
      .rxOut   (rxOut),
      .rxValid (rxValid),
      .rxReady (rxReady),
      .rxBusy  (rxBusy),
      .rxErr   (rxErr),
      .rxOvr   (rxOvr),
      .rxBreak (rxBreak)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendFrame(input logic [7:0] d, input int bitClks, input logic stopVal);
      rxIn = 1'b0;
      clocks(bitClks);
      for (int i = 0; i < 8; i++) begin
         rxIn = d[i];
         clocks(bitClks);
      end
`ifdef UART_RX_PARITY_EN
      rxIn = ^d;
      clocks(bitClks);
`endif
      rxIn = stopVal;
      clocks(bitClks);
   endtask

   // Scoreboard: every accepted byte must match the head of the queue.
   always @(negedge clk) begin
      if (rstn) begin
         if (rxErr)  errCnt++;
         if (rxOvr)  ovrCnt++;
         if (rxBusy) busyCnt++;
         if (rxValid && rxReady) begin
            check("rx byte expected", 16'(expQ.size() != 0), 16'd1);
            if (expQ.size() != 0) check("rxOut", {8'h00, rxOut}, {8'h00, expQ.pop_front()});
         end
      end
   end

   initial begin
      int e0, o0, b0;

      clocks(5);
      check("reset rxOut",   {8'h00, rxOut}, 16'h0000);
      check("reset rxValid", 16'(rxValid), 16'd0);
      check("reset rxBusy",  16'(rxBusy),  16'd0);
      check("reset rxErr",   16'(rxErr),   16'd0);
      check("reset rxOvr",   16'(rxOvr),   16'd0);
      check("reset rxBreak", 16'(rxBreak), 16'd0);
      rstn = 1'b1;
      rxEn = 1'b1;
      clocks(10);

      // back-to-back frames, no idle gap
      rxReady = 1'b1;
      e0 = errCnt; o0 = ovrCnt;
      expQ.push_back(8'h7A);
      expQ.push_back(8'hB1);
      sendFrame(8'h7A, BIT_CLKS, 1'b1);
      sendFrame(8'hB1, BIT_CLKS, 1'b1);
      rxIn = 1'b1;
      clocks(40);
      check("turbo rxErr count", 16'(errCnt - e0), 16'd0);
      check("turbo rxOvr count", 16'(ovrCnt - o0), 16'd0);
      check("turbo bytes left",  16'(expQ.size()), 16'd0);

      // 0.3-bit glitch: false start
      e0 = errCnt; b0 = busyCnt;
      rxIn = 1'b0;
      clocks(19);
      rxIn = 1'b1;
      clocks(2 * BIT_CLKS);
      check("glitch busy seen", 16'(busyCnt > b0), 16'd1);
      check("glitch busy end",  16'(rxBusy), 16'd0);
      check("glitch rxErr",     16'(errCnt - e0), 16'd0);
      check("glitch rxValid",   16'(rxValid), 16'd0);

      // stop bit forced low
      e0 = errCnt;
      sendFrame(8'h55, BIT_CLKS, 1'b0);
      rxIn = 1'b1;
      clocks(BIT_CLKS);
      check("framing rxErr",   16'(errCnt - e0), 16'd1);
      check("framing rxValid", 16'(rxValid), 16'd0);
      check("framing rxBreak", 16'(rxBreak), 16'd0);

      // break: line low for two frames
      e0 = errCnt;
      rxIn = 1'b0;
      clocks(20 * BIT_CLKS);
      check("break rxBreak set", 16'(rxBreak), 16'd1);
      check("break rxErr",       16'(errCnt - e0), 16'd1);
      check("break no rearm",    16'(rxBusy), 16'd0);
      rxIn = 1'b1;
      clocks(8);
      check("break rxBreak clr", 16'(rxBreak), 16'd0);
      check("break rxValid",     16'(rxValid), 16'd0);
      clocks(BIT_CLKS);

      // rxEn dropped mid-frame
      e0 = errCnt;
      rxIn = 1'b0;
      clocks(BIT_CLKS);
      rxIn = 1'b1;
      clocks(3 * BIT_CLKS);
      check("en busy mid", 16'(rxBusy), 16'd1);
      rxEn = 1'b0;
      clocks(2);
      check("en busy drop", 16'(rxBusy), 16'd0);
      rxIn = 1'b0;
      clocks(3 * BIT_CLKS);
      rxIn = 1'b1;
      clocks(3 * BIT_CLKS);
      rxEn = 1'b1;
      clocks(BIT_CLKS);
      check("en rxErr",   16'(errCnt - e0), 16'd0);
      check("en rxValid", 16'(rxValid), 16'd0);

      // stalled consumer: second byte overruns
      rxReady = 1'b0;
      o0 = ovrCnt;
      expQ.push_back(8'h11);
      sendFrame(8'h11, BIT_CLKS, 1'b1);
      clocks(BIT_CLKS);
      sendFrame(8'h22, BIT_CLKS, 1'b1);
      clocks(40);
      check("stall rxValid", 16'(rxValid), 16'd1);
      check("stall rxOut",   {8'h00, rxOut}, 16'h0011);
      check("stall rxOvr",   16'(ovrCnt - o0), 16'd1);
      rxReady = 1'b1;
      clocks(2);
      check("stall drained", 16'(rxValid), 16'd0);

      // about 3% baud mismatch either way
      e0 = errCnt;
      expQ.push_back(8'h96);
      expQ.push_back(8'h69);
      sendFrame(8'h96, 62, 1'b1);
      sendFrame(8'h69, 66, 1'b1);
      clocks(BIT_CLKS);
      check("drift rxErr",      16'(errCnt - e0), 16'd0);
      check("drift bytes left", 16'(expQ.size()), 16'd0);

      // reset during data bit 4 of 0xA5
      rxIn = 1'b0;
      clocks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rxIn = (8'hA5 >> i) & 8'h01;
         clocks(BIT_CLKS);
      end
      rxIn = 1'b0;
      clocks(BIT_CLKS / 2);
      rstn = 1'b0;
      clocks(3);
      rxIn = 1'b1;
      clocks(3);
      rstn = 1'b1;
      clocks(1);
      check("rst rxOut",   {8'h00, rxOut}, 16'h0000);
      check("rst rxValid", 16'(rxValid), 16'd0);
      check("rst rxBusy",  16'(rxBusy),  16'd0);
      check("rst rxErr",   16'(rxErr),   16'd0);
      check("rst rxOvr",   16'(rxOvr),   16'd0);
      check("rst rxBreak", 16'(rxBreak), 16'd0);
      e0 = errCnt;
      clocks(6 * BIT_CLKS);
      check("rst no flags", 16'(errCnt - e0), 16'd0);
      expQ.push_back(8'h3C);
      sendFrame(8'h3C, BIT_CLKS, 1'b1);
      clocks(BIT_CLKS);
      check("final bytes left", 16'(expQ.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
